// File: rtl/quad_decoder_px.sv
// rtl/quad_decoder_px.sv - quadrature decoder and position counter with index and latch capture
module quad_decoder_px #(
    parameter int WIDTH         = 32,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    input  logic             idx,
    input  logic [1:0]       mode,
    input  logic             zero,
    input  logic             idx_clr_en,
    input  logic             latch,
    input  logic             err_clr,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] latched,
    output logic [WIDTH-1:0] idx_pos,
    output logic             idx_seen,
    output logic             err,
    output logic             step,
    output logic             dir
);

    localparam logic ST_INIT = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam int INIT_N = SYNC_STAGES + FILTER_CYCLES;
    localparam int IW     = $clog2(INIT_N + 1);
    localparam int RW     = $clog2(FILTER_CYCLES + 1);
    localparam logic [IW-1:0]    INIT_LAST = IW'(INIT_N - 1);
    localparam logic [RW-1:0]    RUN_LAST  = RW'(FILTER_CYCLES - 1);
    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

    logic          state;
    logic [IW-1:0] init_cnt;
    logic          in_init;
    logic [2:0]    raw;
    logic [2:0]    filt;

    assign in_init = (state == ST_INIT);
    assign raw     = {a, b, idx};

    // Channel order: [2]=a, [1]=b, [0]=idx
    for (genvar i = 0; i < 3; i++) begin : g_chan
        logic [SYNC_STAGES-1:0] sync_q;
        logic [RW-1:0]          run_q;
        logic                   filt_q;
        logic                   sync_val;

        assign sync_val = sync_q[SYNC_STAGES-1];
        assign filt[i]  = filt_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync_q <= '0;
                run_q  <= '0;
                filt_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], raw[i]};
                if (in_init) begin
                    filt_q <= sync_val;
                    run_q  <= '0;
                end else if (sync_val != filt_q) begin
                    if (run_q == RUN_LAST) begin
                        filt_q <= sync_val;
                        run_q  <= '0;
                    end else begin
                        run_q <= run_q + 1'b1;
                    end
                end else begin
                    run_q <= '0;
                end
            end
        end
    end

    logic       pa, pb, pidx;
    logic [1:0] cur, prev, changed, next_up;
    logic       single, both, is_up, a_chg;
    logic       step_req, dir_req, idx_rise, idx_clear;

    assign cur     = {filt[2], filt[1]};
    assign prev    = {pa, pb};
    assign changed = cur ^ prev;
    assign both    = &changed;
    assign single  = ^changed;
    assign a_chg   = changed[1];

    // Up sequence 00 -> 10 -> 11 -> 01 -> 00
    always_comb begin
        next_up = 2'b00;
        case (prev)
            2'b00:   next_up = 2'b10;
            2'b10:   next_up = 2'b11;
            2'b11:   next_up = 2'b01;
            default: next_up = 2'b00;
        endcase
    end

    assign is_up = (cur == next_up);

    always_comb begin
        step_req = 1'b0;
        dir_req  = is_up;
        case (mode)
            2'b01: step_req = single & a_chg;
            2'b10: begin
                step_req = single & a_chg & ~filt[1];
                dir_req  = filt[2];
            end
            default: step_req = single;
        endcase
    end

    assign idx_rise  = ~in_init & filt[0] & ~pidx;
    assign idx_clear = idx_rise & idx_clr_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            pa       <= 1'b0;
            pb       <= 1'b0;
            pidx     <= 1'b0;
            count    <= '0;
            latched  <= '0;
            idx_pos  <= '0;
            idx_seen <= 1'b0;
            err      <= 1'b0;
            step     <= 1'b0;
            dir      <= 1'b0;
        end else begin
            pidx <= filt[0];
            step <= 1'b0;
            if (latch) begin
                latched <= count;
            end
            if (in_init) begin
                if (init_cnt == INIT_LAST) begin
                    state <= ST_RUN;
                    pa    <= filt[2];
                    pb    <= filt[1];
                end else begin
                    init_cnt <= init_cnt + 1'b1;
                end
                if (zero) begin
                    count    <= '0;
                    idx_seen <= 1'b0;
                end else if (err_clr) begin
                    err <= 1'b0;
                end
            end else begin
                pa <= filt[2];
                pb <= filt[1];
                if (both) begin
                    err <= 1'b1;
                end else if (err_clr) begin
                    err <= 1'b0;
                end
                if (idx_rise) begin
                    idx_pos <= count;
                end
                if (zero) begin
                    idx_seen <= 1'b0;
                end else if (idx_rise) begin
                    idx_seen <= 1'b1;
                end
                // A step that collides with a clear is dropped entirely
                if (zero || idx_clear) begin
                    count <= '0;
                end else if (step_req) begin
                    count <= dir_req ? count + ONE : count - ONE;
                    step  <= 1'b1;
                    dir   <= dir_req;
                end
            end
        end
    end

endmodule

// File: tb/tb_quad_decoder_px.sv
// tb/tb_quad_decoder_px.sv - table-driven self-checking bench for quad_decoder_px
module tb_quad_decoder_px;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a = 1'b1, b = 1'b1, idx = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        zero = 1'b0, idx_clr_en = 1'b0, latch = 1'b0, err_clr = 1'b0;
    logic [31:0] count, latched, idx_pos;
    logic        idx_seen, err, step, dir;

    logic        a8 = 1'b0, b8 = 1'b0;
    logic [7:0]  count8, latched8, idx_pos8;
    logic        idx_seen8, err8, step8, dir8;

    int n_cmp = 0;
    int n_bad = 0;
    int step_cnt = 0;
    int step_mark;

    always #5 clk = ~clk;

    quad_decoder_px dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .idx(idx), .mode(mode),
        .zero(zero), .idx_clr_en(idx_clr_en), .latch(latch), .err_clr(err_clr),
        .count(count), .latched(latched), .idx_pos(idx_pos), .idx_seen(idx_seen),
        .err(err), .step(step), .dir(dir)
    );

    quad_decoder_px #(.WIDTH(8), .SYNC_STAGES(2), .FILTER_CYCLES(1)) dut8 (
        .clk(clk), .reset(reset), .a(a8), .b(b8), .idx(1'b0), .mode(2'b00),
        .zero(1'b0), .idx_clr_en(1'b0), .latch(1'b0), .err_clr(1'b0),
        .count(count8), .latched(latched8), .idx_pos(idx_pos8), .idx_seen(idx_seen8),
        .err(err8), .step(step8), .dir(dir8)
    );

    always @(negedge clk) begin
        if (step) step_cnt++;
    end

    typedef struct {
        logic        va;
        logic        vb;
        logic [1:0]  vmode;
        logic [31:0] exp_count;
        logic        exp_dir;
    } vec_t;

    vec_t tbl [0:25];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic edge_ab(input logic na, input logic nb, input int wait_cycles);
        @(negedge clk);
        a = na;
        b = nb;
        ticks(wait_cycles);
    endtask

    function automatic vec_t mk(input logic va, input logic vb, input logic [1:0] m,
                                input logic [31:0] c, input logic d);
        vec_t v;
        v.va = va; v.vb = vb; v.vmode = m; v.exp_count = c; v.exp_dir = d;
        return v;
    endfunction

    // Forward step from the current a/b state along 00->10->11->01->00
    task automatic fwd(input int wait_cycles);
        logic [1:0] s;
        s = {a, b};
        case (s)
            2'b00:   edge_ab(1'b1, 1'b0, wait_cycles);
            2'b10:   edge_ab(1'b1, 1'b1, wait_cycles);
            2'b11:   edge_ab(1'b0, 1'b1, wait_cycles);
            default: edge_ab(1'b0, 1'b0, wait_cycles);
        endcase
    endtask

    task automatic fwd8;
        logic [1:0] s;
        s = {a8, b8};
        @(negedge clk);
        case (s)
            2'b00:   begin a8 = 1'b1; b8 = 1'b0; end
            2'b10:   begin a8 = 1'b1; b8 = 1'b1; end
            2'b11:   begin a8 = 1'b0; b8 = 1'b1; end
            default: begin a8 = 1'b0; b8 = 1'b0; end
        endcase
        ticks(6);
    endtask

    initial begin
        tbl[0]  = mk(0, 0, 2'b00, 32'd2, 1'b1);
        tbl[1]  = mk(1, 0, 2'b00, 32'd3, 1'b1);
        tbl[2]  = mk(1, 1, 2'b00, 32'd4, 1'b1);
        tbl[3]  = mk(0, 1, 2'b00, 32'd5, 1'b1);
        tbl[4]  = mk(0, 0, 2'b00, 32'd6, 1'b1);
        tbl[5]  = mk(1, 0, 2'b00, 32'd7, 1'b1);
        tbl[6]  = mk(1, 1, 2'b00, 32'd8, 1'b1);
        tbl[7]  = mk(1, 0, 2'b00, 32'd7, 1'b0);
        tbl[8]  = mk(0, 0, 2'b00, 32'd6, 1'b0);
        tbl[9]  = mk(0, 1, 2'b00, 32'd5, 1'b0);
        tbl[10] = mk(0, 0, 2'b10, 32'd5, 1'b0);
        tbl[11] = mk(1, 0, 2'b10, 32'd6, 1'b1);
        tbl[12] = mk(1, 1, 2'b10, 32'd6, 1'b1);
        tbl[13] = mk(0, 1, 2'b10, 32'd6, 1'b1);
        tbl[14] = mk(1, 1, 2'b10, 32'd6, 1'b1);
        tbl[15] = mk(1, 0, 2'b10, 32'd6, 1'b1);
        tbl[16] = mk(0, 0, 2'b10, 32'd5, 1'b0);
        tbl[17] = mk(0, 1, 2'b10, 32'd5, 1'b0);
        tbl[18] = mk(0, 0, 2'b01, 32'd5, 1'b0);
        tbl[19] = mk(1, 0, 2'b01, 32'd6, 1'b1);
        tbl[20] = mk(1, 1, 2'b01, 32'd6, 1'b1);
        tbl[21] = mk(0, 1, 2'b01, 32'd7, 1'b1);
        tbl[22] = mk(1, 1, 2'b01, 32'd6, 1'b0);
        tbl[23] = mk(1, 0, 2'b01, 32'd6, 1'b0);
        tbl[24] = mk(0, 0, 2'b01, 32'd5, 1'b0);
        tbl[25] = mk(0, 1, 2'b01, 32'd5, 1'b0);

        // Reset state
        ticks(2);
        check("rst_count", count, 32'd0);
        check("rst_latched", latched, 32'd0);
        check("rst_idx_pos", idx_pos, 32'd0);
        check("rst_flags", {28'd0, idx_seen, err, step, dir}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ticks(20);
        check("init_count", count, 32'd0);
        check("init_err", {31'd0, err}, 32'd0);
        check("init_steps", step_cnt, 32'd0);

        // First edge: update must land exactly at edge 7
        @(negedge clk);
        a = 1'b0;
        ticks(6);
        check("lat_e6_count", count, 32'd0);
        check("lat_e6_step", {31'd0, step}, 32'd0);
        ticks(1);
        check("lat_e7_count", count, 32'd1);
        check("lat_e7_step", {31'd0, step}, 32'd1);
        check("lat_e7_dir", {31'd0, dir}, 32'd1);
        ticks(3);

        for (int i = 0; i < 26; i++) begin
            mode = tbl[i].vmode;
            edge_ab(tbl[i].va, tbl[i].vb, 10);
            check($sformatf("vec%0d_count", i), count, tbl[i].exp_count);
            check($sformatf("vec%0d_dir", i), {31'd0, dir}, {31'd0, tbl[i].exp_dir});
            if (i == 6) check("x4_step_pulses", step_cnt, 32'd8);
        end
        mode = 2'b00;

        // Short glitch on A is filtered out
        @(negedge clk);
        a = 1'b1;
        ticks(3);
        @(negedge clk);
        a = 1'b0;
        ticks(15);
        check("glitch_count", count, 32'd5);

        // Both phases toggle together: illegal
        edge_ab(1'b1, 1'b0, 10);
        check("illegal_err", {31'd0, err}, 32'd1);
        check("illegal_count", count, 32'd5);
        @(negedge clk);
        err_clr = 1'b1;
        ticks(1);
        err_clr = 1'b0;
        check("err_clr", {31'd0, err}, 32'd0);

        // Wrap below zero and back
        @(negedge clk);
        zero = 1'b1;
        ticks(1);
        zero = 1'b0;
        check("zero_count", count, 32'd0);
        edge_ab(1'b0, 1'b0, 10);
        check("wrap_down", count, 32'hFFFF_FFFF);
        edge_ab(1'b1, 1'b0, 10);
        check("wrap_up", count, 32'd0);

        // Index clear coinciding with an A edge
        for (int i = 0; i < 37; i++) fwd(10);
        check("pre_idx_count", count, 32'd37);
        step_mark = step_cnt;
        @(negedge clk);
        idx = 1'b1;
        idx_clr_en = 1'b1;
        a = 1'b0;
        ticks(10);
        check("idx_pos", idx_pos, 32'd37);
        check("idx_seen", {31'd0, idx_seen}, 32'd1);
        check("idx_clr_count", count, 32'd0);
        check("idx_step_dropped", step_cnt - step_mark, 32'd0);
        @(negedge clk);
        idx = 1'b0;
        ticks(10);
        idx_clr_en = 1'b0;

        // Latch and zero together
        for (int i = 0; i < 12; i++) fwd(10);
        check("pre_latch_count", count, 32'd12);
        @(negedge clk);
        latch = 1'b1;
        zero = 1'b1;
        ticks(1);
        latch = 1'b0;
        zero = 1'b0;
        check("latch_val", latched, 32'd12);
        check("latch_zero_count", count, 32'd0);
        check("zero_idx_seen", {31'd0, idx_seen}, 32'd0);
        check("zero_keeps_idx_pos", idx_pos, 32'd37);

        // Signed overflow wrap on a narrow instance
        for (int i = 0; i < 127; i++) fwd8();
        check("w8_max", {24'd0, count8}, 32'h7F);
        fwd8();
        check("w8_wrap", {24'd0, count8}, 32'h80);
        check("w8_err", {31'd0, err8}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/quad_decoder_px.md
Name: quad_decoder_px

Overview:
Parametrised quadrature decoder and position counter with index support for encoder-driven motion channels. It accepts raw asynchronous A/B/index inputs and synchronises and glitch-filters them. It decodes in x4, x2 or x1 resolution, flags illegal transitions, and captures position on index and on a host latch strobe. One instance per encoder channel; outputs feed the register file.

Parameters:
WIDTH, 32, position counter width (two's complement, >=8)
SYNC_STAGES, 2, synchroniser flops per input (>=2)
FILTER_CYCLES, 4, consecutive agreeing synchronised samples required before a filtered input changes (>=1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high; clears all state
a  input  1  quadrature phase A (asynchronous)
b  input  1  quadrature phase B (asynchronous)
idx  input  1  index pulse (asynchronous, active-high)
mode  input  2  00=x4, 01=x2, 10=x1, 11=x4
zero  input  1  synchronous count clear, single-cycle
idx_clr_en  input  1  1 = index rising edge clears count
latch  input  1  capture strobe, single-cycle
err_clr  input  1  clears err
count  output  WIDTH  live signed position
latched  output  WIDTH  position captured by latch
idx_pos  output  WIDTH  position captured at last index edge
idx_seen  output  1  sticky; set on index edge, cleared by zero
err  output  1  sticky illegal-transition flag
step  output  1  one-cycle pulse in any cycle where count steps
dir  output  1  direction of the last step (1=up), held between steps

Behaviour:
- Reset, asynchronous: every output 0. Synchronisers, filters and the previous-state register {pa,pb} are 0. FSM goes to INIT.
- Input path: each input passes through SYNC_STAGES flops, then a filter. Filter rule: a per-channel run counter increments while the synchronised value differs from the filtered value. When the run reaches FILTER_CYCLES, the filtered value takes the synchronised value and the run resets. Any agreeing sample resets the run to 0.
- FSM INIT: a counter runs SYNC_STAGES+FILTER_CYCLES cycles. During INIT, filtered values copy the synchronised values directly. No count, err, step or index events occur. On exit, {pa,pb} is loaded from the filtered values and the FSM goes to RUN. The FSM returns to INIT only on reset.
- RUN decode: compare the filtered {fa,fb} against {pa,pb} every cycle, then {pa,pb} <= {fa,fb}.
  - Up direction: A leads B, sequence 00->10->11->01->00. Down is the reverse.
  - Both bits changed in one cycle: set err, no step.
  - x4: step on every single-bit change.
  - x2: step only on changes of A; direction as x4.
  - x1: up on A rising while B=0; down on A falling while B=0; no other steps.
- Count arithmetic: count +/-1 modulo 2^WIDTH, with silent wrap (0x7FFFFFFF+1 -> 0x80000000; 0-1 -> all ones).
- Latency: from an input change stable before edge 1, count, step and dir update at edge SYNC_STAGES+FILTER_CYCLES+1. With defaults, that is edge 7.
- Index: a filtered idx rising edge, in RUN only, loads idx_pos with count's pre-update value and sets idx_seen. If idx_clr_en=1, count <= 0 in the same cycle.
- Priority on count per cycle: reset > zero > index clear > step. A step coinciding with zero or with an index clear is discarded; step stays 0, dir is unchanged.
- zero: count <= 0 and idx_seen <= 0. zero does not affect latched, idx_pos or err.
- latch: latched <= count's pre-update value at that edge. latch and zero together means latched gets the pre-zero value.
- err: sticky until err_clr. When err_clr and a new illegal transition coincide, err stays 1.
- mode changes take effect the next cycle; the count is not altered.

Test Plan:
- Release reset with a=b=1 held -> after INIT: count=0, err=0, no step.
- Defaults, x4: 8 forward edges (2 full cycles) -> count=8, dir=1, 8 step pulses. Each update lands 7 clocks after its edge. Then 3 reverse edges -> count=5, dir=0.
- x1, 1 forward and 1 reverse full cycle -> count +1 then 0. x2, same stimulus -> +2 then 0.
- Glitch on A of 3 clocks (<FILTER_CYCLES) -> no count change. Force a and b to toggle together -> err=1, count unchanged. err_clr -> err=0.
- count=0, 1 reverse x4 edge -> count=all ones, then 1 forward edge -> 0. Preload count to 0x7FFFFFFF, then 1 forward edge -> 0x80000000.
- count=37, idx pulse with idx_clr_en=1 and a coincident A edge -> idx_pos=37, idx_seen=1, count=0. Then latch and zero in the same cycle at count=12 -> latched=12, count=0, idx_seen=0.
